// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;
    localparam int WAIT_W = 4;

    localparam logic [REG_W-1:0] ZERO_REG_DEFAULT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding MDU results waiting for the register-file write port.
module wb_fifo2
    import wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic [1:0] count,
    output wb_entry_t head
);

    logic [1:0] count_reg, count_next;
    logic       wr_ptr_reg, rd_ptr_reg;
    logic       do_push, do_pop;
    wb_entry_t  slot [2];

    assign do_push = push && (count_reg != 2'd2);
    assign do_pop  = pop  && (count_reg != 2'd0);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Payload slots carry no reset; validity is tracked by count_reg alone.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            wb_entry_t entry_reg;
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == 1'(gi))) entry_reg <= push_entry;
            end
            assign slot[gi] = entry_reg;
        end
    endgenerate

    assign count = count_reg;
    assign head  = slot[rd_ptr_reg];

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between writeback and the MDU with starvation forcing.
// Optional WB_ARB_PERF_EN adds StallCount / MduWrites performance counters.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned      STARVE_LIMIT = 4,
    parameter logic [REG_W-1:0] ZERO_REG     = ZERO_REG_DEFAULT
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PipeRegWrite,
    input  logic [REG_W-1:0]  PipeReg,
    input  logic [DATA_W-1:0] PipeData,
    input  logic              MduValid,
    input  logic [REG_W-1:0]  MduReg,
    input  logic [DATA_W-1:0] MduData,
    output logic              MduReady,
    output logic              PipeStall,
    output logic              RFWrite,
    output logic [REG_W-1:0]  RFReg,
    output logic [DATA_W-1:0] RFData
`ifdef WB_ARB_PERF_EN
   ,output logic [31:0]       StallCount,
    output logic [31:0]       MduWrites
`endif
);

    wb_state_t         state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next, wait_inc;
    logic [1:0]        fifo_count;
    wb_entry_t         fifo_head, mdu_entry;
    logic              push, pop;
    logic              grant_valid;
    logic [REG_W-1:0]  grant_reg;
    logic [DATA_W-1:0] grant_data;
    logic              rf_write_reg;
    logic [REG_W-1:0]  rf_reg_reg;
    logic [DATA_W-1:0] rf_data_reg;

    assign MduReady  = (fifo_count < 2'd2);
    assign push      = MduValid && MduReady;
    assign mdu_entry = '{rd: MduReg, data: MduData};
    assign PipeStall = (state_reg == ST_FORCE);
    assign wait_inc  = wait_reg + 1'b1;

    wb_fifo2 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (mdu_entry),
        .pop        (pop),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    always_comb begin
        state_next  = state_reg;
        wait_next   = wait_reg;
        pop         = 1'b0;
        grant_valid = 1'b0;
        grant_reg   = PipeReg;
        grant_data  = PipeData;
        case (state_reg)
            ST_IDLE: begin
                grant_valid = PipeRegWrite;
                wait_next   = '0;
                if (push) state_next = ST_PEND;
            end
            ST_PEND: begin
                if (PipeRegWrite) begin
                    grant_valid = 1'b1;
                    wait_next   = wait_inc;
                    if (wait_inc >= WAIT_W'(STARVE_LIMIT)) state_next = ST_FORCE;
                end else begin
                    pop         = 1'b1;
                    grant_valid = 1'b1;
                    grant_reg   = fifo_head.rd;
                    grant_data  = fifo_head.data;
                    wait_next   = '0;
                    if ((fifo_count == 2'd1) && !push) state_next = ST_IDLE;
                end
            end
            ST_FORCE: begin
                // Pipeline request is ignored here; the stalled stage re-presents it.
                pop         = 1'b1;
                grant_valid = 1'b1;
                grant_reg   = fifo_head.rd;
                grant_data  = fifo_head.data;
                wait_next   = '0;
                state_next  = ((fifo_count == 2'd1) && !push) ? ST_IDLE : ST_PEND;
            end
            default: begin
                state_next = ST_IDLE;
                wait_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // Writes to the zero register still consume the grant but never assert the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_reg <= 1'b0;
            rf_reg_reg   <= '0;
            rf_data_reg  <= '0;
        end else begin
            rf_write_reg <= grant_valid && (grant_reg != ZERO_REG);
            if (grant_valid) begin
                rf_reg_reg  <= grant_reg;
                rf_data_reg <= grant_data;
            end
        end
    end

    assign RFWrite = rf_write_reg;
    assign RFReg   = rf_reg_reg;
    assign RFData  = rf_data_reg;

`ifdef WB_ARB_PERF_EN
    logic [31:0] stall_count_reg, mdu_writes_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
            mdu_writes_reg  <= '0;
        end else begin
            if (PipeStall) stall_count_reg <= stall_count_reg + 32'd1;
            if (pop)       mdu_writes_reg  <= mdu_writes_reg + 32'd1;
        end
    end

    assign StallCount = stall_count_reg;
    assign MduWrites  = mdu_writes_reg;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

    localparam int         LIMIT = 4;
    localparam logic [4:0] ZR    = 5'd31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PipeRegWrite = 1'b0;
    logic [4:0]  PipeReg = '0;
    logic [63:0] PipeData = '0;
    logic        MduValid = 1'b0;
    logic [4:0]  MduReg = '0;
    logic [63:0] MduData = '0;
    logic        MduReady, PipeStall, RFWrite;
    logic [4:0]  RFReg;
    logic [63:0] RFData;

    wb_arbiter #(.STARVE_LIMIT(LIMIT), .ZERO_REG(ZR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PipeRegWrite (PipeRegWrite),
        .PipeReg      (PipeReg),
        .PipeData     (PipeData),
        .MduValid     (MduValid),
        .MduReg       (MduReg),
        .MduData      (MduData),
        .MduReady     (MduReady),
        .PipeStall    (PipeStall),
        .RFWrite      (RFWrite),
        .RFReg        (RFReg),
        .RFData       (RFData)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_seen = 0;

    // Reference model: pending MDU results, head wait time, and a pending forced grant.
    typedef struct { logic [4:0] r; logic [63:0] d; } ent_t;
    ent_t q[$];
    int   waited = 0;
    bit   stall_now = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic prw, input logic [4:0] pr, input logic [63:0] pd,
                        input logic mv, input logic [4:0] mr, input logic [63:0] md,
                        input string tag, output bit pacc, output bit macc);
        ent_t        e;
        bit          g, rdy;
        logic [4:0]  gr;
        logic [63:0] gd;
        @(negedge clk);
        PipeRegWrite = prw; PipeReg = pr; PipeData = pd;
        MduValid = mv; MduReg = mr; MduData = md;
        #1;
        rdy = (q.size() < 2);
        check({tag, "_ready"}, 64'(MduReady), 64'(rdy));
        check({tag, "_stall"}, 64'(PipeStall), 64'(stall_now));
        if (PipeStall === 1'b1) stall_seen++;
        pacc = prw && !stall_now;
        macc = mv && rdy;
        g = 1'b0; gr = '0; gd = '0;
        if (stall_now) begin
            e = q.pop_front(); g = 1'b1; gr = e.r; gd = e.d;
            waited = 0; stall_now = 1'b0;
        end else if (prw) begin
            g = 1'b1; gr = pr; gd = pd;
            if (q.size() != 0) begin
                waited++;
                if (waited == LIMIT) stall_now = 1'b1;
            end
        end else if (q.size() != 0) begin
            e = q.pop_front(); g = 1'b1; gr = e.r; gd = e.d;
            waited = 0;
        end
        if (macc) q.push_back('{r: mr, d: md});
        @(posedge clk);
        #1;
        check({tag, "_rfwrite"}, 64'(RFWrite), 64'(g && gr != ZR));
        if (g && gr != ZR) begin
            check({tag, "_rfreg"}, 64'(RFReg), 64'(gr));
            check({tag, "_rfdata"}, RFData, gd);
            $display("[%0t] %s write r%0d = 0x%0h", $time, tag, RFReg, RFData);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        PipeRegWrite = 1'b0; MduValid = 1'b0;
        #1;
        check({tag, "_rfwrite"}, 64'(RFWrite), 64'd0);
        check({tag, "_rfreg"}, 64'(RFReg), 64'd0);
        check({tag, "_rfdata"}, RFData, 64'd0);
        check({tag, "_stall"}, 64'(PipeStall), 64'd0);
        check({tag, "_ready"}, 64'(MduReady), 64'd1);
        q.delete(); waited = 0; stall_now = 1'b0;
        $display("[%0t] %s applied", $time, tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return ZR;
        return 5'($urandom_range(0, 30));
    endfunction

    initial begin
        bit          pacc, macc;
        int          s0, n, guard;
        logic        prw, mv;
        logic [4:0]  pr, mr;
        logic [63:0] pd, md;

        apply_reset("reset");

        // Pipeline-only write
        step(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0, "pipe", pacc, macc);
        check("pipe_fixed_data", RFData, 64'hAA);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "pipe_idle", pacc, macc);

        // MDU-only write
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h1234, "mdu_push", pacc, macc);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "mdu_grant", pacc, macc);
        check("mdu_fixed_reg", 64'(RFReg), 64'd7);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "mdu_idle", pacc, macc);

        // Starvation with a continuously busy pipeline
        s0 = stall_seen;
        step(1'b1, 5'd10, 64'd100, 1'b1, 5'd9, 64'h9999, "starve", pacc, macc);
        n = 1;
        guard = 0;
        while (n < 8 && guard < 20) begin
            step(1'b1, 5'(10 + n), 64'(100 + n), 1'b0, 5'd0, 64'd0, "starve", pacc, macc);
            if (pacc) n++;
            guard++;
        end
        check("starve_stall_cycles", 64'(stall_seen - s0), 64'd1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "starve_idle", pacc, macc);

        // Full FIFO with busy pipeline; third offer must wait
        step(1'b1, 5'd1, 64'h11, 1'b1, 5'd21, 64'hA1, "full", pacc, macc);
        step(1'b1, 5'd2, 64'h12, 1'b1, 5'd22, 64'hA2, "full", pacc, macc);
        check("full_ready_low", 64'(MduReady), 64'd0);
        macc = 1'b0;
        guard = 0;
        n = 3;
        while (!macc && guard < 20) begin
            step(1'b1, 5'(n), 64'(16 + n), 1'b1, 5'd23, 64'hA3, "full", pacc, macc);
            if (pacc) n++;
            guard++;
        end
        check("full_third_accepted", 64'(macc), 64'd1);
        repeat (4) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "full_drain", pacc, macc);

        // Zero register from both sources
        step(1'b1, ZR, 64'h55, 1'b0, 5'd0, 64'd0, "zero_pipe", pacc, macc);
        step(1'b0, 5'd0, 64'd0, 1'b1, ZR, 64'h66, "zero_push", pacc, macc);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "zero_pop", pacc, macc);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "zero_idle", pacc, macc);

        // Reset while forcing with two entries pending
        step(1'b1, 5'd3, 64'h31, 1'b1, 5'd13, 64'hB1, "rst_mid", pacc, macc);
        step(1'b1, 5'd4, 64'h32, 1'b1, 5'd14, 64'hB2, "rst_mid", pacc, macc);
        guard = 0;
        while (!stall_now && guard < 10) begin
            step(1'b1, 5'd5, 64'h33, 1'b0, 5'd0, 64'd0, "rst_mid", pacc, macc);
            guard++;
        end
        check("rst_mid_in_force", 64'(PipeStall), 64'd1);
        apply_reset("rst_force");
        repeat (4) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "rst_after", pacc, macc);

        // Randomized traffic; stalled pipeline writes and unaccepted MDU offers are held
        prw = 1'b0; pr = '0; pd = '0; mv = 1'b0; mr = '0; md = '0;
        pacc = 1'b0; macc = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!prw || pacc) begin
                prw = ($urandom_range(0, 9) < 7);
                pr  = rnd_reg();
                pd  = {$urandom, $urandom};
            end
            if (!mv || macc) begin
                mv = ($urandom_range(0, 9) < 4);
                mr = rnd_reg();
                md = {$urandom, $urandom};
            end
            step(prw, pr, pd, mv, mr, md, "rnd", pacc, macc);
        end
        repeat (6) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "final_drain", pacc, macc);
        check("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- STARVE_LIMIT, 4, MDU head-wait cycles before forcing a pipeline stall (1..15).
- ZERO_REG, 31, register index whose writes are discarded (XZR).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- PipeRegWrite, in, 1, writeback stage requests a write this cycle.
- PipeReg, in, 5, writeback destination register.
- PipeData, in, 64, writeback data (already MemToReg-selected).
- MduValid, in, 1, multi-cycle unit offers a result.
- MduReg, in, 5, MDU destination register.
- MduData, in, 64, MDU result.
- MduReady, out, 1, arbiter accepts the MDU result this cycle.
- PipeStall, out, 1, pipeline must hold writeback this cycle.
- RFWrite, out, 1, register-file write enable.
- RFReg, out, 5, register-file write address.
- RFData, out, 64, register-file write data.

Function
REQ-003 Block SHALL share the single register-file write port between the writeback stage and the MDU.
REQ-004 MDU results SHALL enter a 2-entry FIFO; transfer occurs when MduValid and MduReady are both 1 on a rising edge.
REQ-005 MduReady SHALL equal (FIFO count < 2) and SHALL depend on registered state only.
REQ-006 RFWrite, RFReg and RFData SHALL be registered: a grant at edge t appears on the port during cycle t+1.
REQ-007 FSM states: IDLE (FIFO empty), PEND (FIFO non-empty, pipeline has priority), FORCE (PipeStall=1, FIFO head granted).
REQ-008 IDLE: grant pipeline if PipeRegWrite; go to PEND on any MDU push.
REQ-009 PEND: grant pipeline if PipeRegWrite; otherwise pop and grant FIFO head; wait counter increments each cycle the head is not granted and clears on pop.
REQ-010 PEND to FORCE when the wait counter reaches STARVE_LIMIT; PipeStall SHALL be 1 exactly in FORCE.
REQ-011 FORCE: ignore pipeline inputs, pop and grant head, clear counter; next state PEND if FIFO remains non-empty, else IDLE; the pipeline re-presents its write next cycle.
REQ-012 PEND to IDLE when the last entry pops and no push occurs in the same cycle.
REQ-013 Push and pop in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-014 A grant to ZERO_REG SHALL consume the request (pops FIFO if MDU) but drive RFWrite=0.
REQ-015 The block SHALL NOT reorder or check same-register hazards; writes retire in grant order, and ordering is the hazard unit's responsibility.

Reset
REQ-016 rst_n low SHALL immediately force: FSM IDLE, FIFO count 0, wait counter 0, RFWrite 0, RFReg 0, RFData 0, PipeStall 0; MduReady reads 1 after release.
REQ-017 Reset mid-operation SHALL discard pending FIFO entries without writing them.

Configuration
REQ-018 With WB_ARB_PERF_EN defined: extra outputs StallCount[31:0] (cycles in FORCE) and MduWrites[31:0] (FIFO pops), both wrap at 2^32 and reset to 0. Without it: these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-019 Shared package wb_pkg SHALL hold the FSM state enum, REG_W=5, DATA_W=64 and the ZERO_REG default.
REQ-020 The FIFO SHALL be a sub-module wb_fifo2 (2-entry, push/pop/count); the FSM and output register live in wb_arbiter.

Verification
REQ-021 Pipeline only: PipeRegWrite=1, PipeReg=5, PipeData=0xAA for 1 cycle -> next cycle RFWrite=1, RFReg=5, RFData=0xAA; PipeStall stays 0.
REQ-022 MDU only: push (Reg=7, Data=0x1234) with pipeline idle -> written one cycle after grant; FSM returns to IDLE.
REQ-023 Starvation: one MDU entry, PipeRegWrite=1 every cycle, STARVE_LIMIT=4 -> PipeStall=1 for exactly one cycle after 4 wait cycles; the MDU entry is written next; no pipeline write is lost.
REQ-024 Full FIFO: two pushes with the pipeline busy -> MduReady=0; a third MduValid stays pending until the first pop; order is preserved.
REQ-025 Zero register: PipeReg=31 or MduReg=31 -> RFWrite=0 and the FIFO still pops.
REQ-026 Reset while 2 entries are pending and FSM is in FORCE -> all outputs 0 immediately; no stale write appears after release.
